// File: rtl/queue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// queue_ctrl_pkg
//
// Shared definitions for controllers that front a registered-output `queue`:
//   - ST_EMPTY / ST_VALID : output-stage state encoding. Plain localparams keep
//                           the encoding usable from legacy Verilog-style
//                           case/compare code.
//   - wrap_inc()          : modulo increment for round-robin pointers. It works
//                           for any requester count, not only powers of two.
// -----------------------------------------------------------------------------
package queue_ctrl_pkg;

  // Output stage: no word is presented (EMPTY), or q_dout is presented (VALID).
  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_VALID = 1'b1;

  // (idx + 1) mod n for 0 <= idx < n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/queue_ctrl_rr_arbiter.sv
// -----------------------------------------------------------------------------
// queue_ctrl_rr_arbiter
//
// Round-robin arbiter. The grant is combinational and the priority pointer is
// registered. The search starts at rr_ptr and moves upward with wrap, so the
// requester that was accepted last gets the lowest priority on the next round.
// The pointer moves only when the parent reports an accept.
//
// Ports:
//   clk      in   clock
//   clear_i  in   synchronous clear of the pointer (reset or flush)
//   req_i    in   [NUM_REQ] request vector
//   accept_i in   the granted request was taken this cycle
//   grant_o  out  [NUM_REQ] one-hot grant (all zero when there is no request)
// -----------------------------------------------------------------------------
module queue_ctrl_rr_arbiter
  import queue_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               clear_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               accept_i,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gnt_idx;
  logic             found;
  int               pos;

  // NOTE: every variable written in an always_comb gets a default value first.
  // Any path that leaves a variable unassigned would infer a latch.
  always_comb begin
    grant_o = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr_q) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && req_i[pos]) begin
        found        = 1'b1;
        grant_o[pos] = 1'b1;
        gnt_idx      = IDX_W'(pos);
      end
    end
  end

  // After an accept, the requester just behind the winner gets first priority.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept_i) rr_ptr_d = IDX_W'(wrap_inc(int'(gnt_idx), NUM_REQ));
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples pre-edge values, whatever order the always blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (clear_i) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/queue_ctrl.sv
// -----------------------------------------------------------------------------
// queue_ctrl
//
// Shares one external `queue` (registered dout and registered empty/full flags)
// between NUM_REQ producers and drains it to a single valid/ready consumer.
//
// Producer side: a round-robin arbiter picks one valid requester. It is accepted
// whenever the queue is not full, and its payload is driven to q_din with
// q_enqueue.
//
// Consumer side: a two-state output stage (EMPTY/VALID) presents q_dout. It
// issues the next dequeue in the same cycle as a consumer transfer, so a
// non-empty queue streams one word per cycle with no bubble.
//
// count = words in the queue + the word held on the output (0..2^DEPTH_INDEX+1).
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   flush      in   synchronous discard of all queued and held data
//   req_valid  in   [NUM_REQ] per-requester valid
//   req_data   in   [NUM_REQ*WIDTH] per-requester payload; requester i sits at
//                   [i*WIDTH +: WIDTH]
//   req_ready  out  [NUM_REQ] one-hot (or zero) accept
//   q_rst      out  rst | flush, wired to the queue reset
//   q_din      out  [WIDTH] payload to the queue
//   q_enqueue  out  queue enqueue
//   q_dequeue  out  queue dequeue
//   q_dout     in   [WIDTH] queue registered output
//   q_empty    in   queue empty flag (registered)
//   q_full     in   queue full flag (registered)
//   out_valid  out  consumer valid
//   out_data   out  [WIDTH] consumer payload
//   out_ready  in   consumer ready
//   count      out  [DEPTH_INDEX+1] entries in the queue plus the held entry
// -----------------------------------------------------------------------------
module queue_ctrl
  import queue_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 32,
  parameter int DEPTH_INDEX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     q_rst,
  output logic [WIDTH-1:0]         q_din,
  output logic                     q_enqueue,
  output logic                     q_dequeue,
  input  logic [WIDTH-1:0]         q_dout,
  input  logic                     q_empty,
  input  logic                     q_full,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [DEPTH_INDEX:0]     count
);

  localparam int DEPTH = 2 ** DEPTH_INDEX;

  logic               clear;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic               xfer;

  logic               state_q, state_d;
  logic [DEPTH_INDEX:0] count_q, count_d;

  // Reset and flush have the same effect on this block and on the queue.
  assign clear = rst | flush;
  assign q_rst = clear;

  // ---------------------------------------------------------------------------
  // Producer side
  // ---------------------------------------------------------------------------
  queue_ctrl_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .clear_i  (clear),
    .req_i    (req_valid),
    .accept_i (accept),
    .grant_o  (grant)
  );

  // The grant already implies req_valid, so any ready bit is an accept.
  // Readiness ignores out_ready. The queue absorbs consumer backpressure.
  assign req_ready = (clear || q_full) ? '0 : grant;
  assign accept    = |req_ready;
  assign q_enqueue = accept;

  // One-hot mux of the granted payload.
  always_comb begin
    q_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) q_din = req_data[i*WIDTH +: WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Consumer side
  // ---------------------------------------------------------------------------
  // Dequeue only when the queue reports non-empty. This means the queue's
  // empty-bypass path is never exercised. A dequeue in a VALID cycle that also
  // transfers refills dout for the next cycle with no gap.
  always_comb begin
    state_d   = state_q;
    q_dequeue = 1'b0;
    if (!clear) begin
      if (state_q == ST_EMPTY) begin
        if (!q_empty) begin
          q_dequeue = 1'b1;
          state_d   = ST_VALID;
        end
      end else if (out_ready) begin
        if (!q_empty) q_dequeue = 1'b1;
        else          state_d   = ST_EMPTY;
      end
    end
  end

  // Forcing valid low during clear means a flush cannot also complete a transfer.
  assign out_valid = (state_q == ST_VALID) && !clear;
  assign out_data  = q_dout;
  assign xfer      = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    unique case ({accept, xfer})
      2'b10:   count_d = (count_q == '1) ? count_q : count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign count = count_q;

  // NOTE: only control state is reset. The data path (q_dout) is never reset.
  // It is hidden behind out_valid, and a cleared output stage stays EMPTY until
  // a new word has been dequeued.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol invariants
  // ---------------------------------------------------------------------------
  a_no_enq_full : assert property (@(posedge clk) disable iff (rst) !(q_enqueue && q_full));
  a_no_deq_empty: assert property (@(posedge clk) disable iff (rst) !(q_dequeue && q_empty));
  a_count_range : assert property (@(posedge clk) disable iff (rst) int'(count_q) <= DEPTH + 1);

endmodule

// File: tb/tb_queue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_queue_ctrl
//
// Testbench for queue_ctrl with NUM_REQ=4, WIDTH=32, DEPTH_INDEX=2.
//
// The attached queue is a behavioural model here. It has registered dout and
// registered empty/full flags, and depth 4.
//
// The controller reference is a transaction-level scoreboard. Each accepted word
// is recorded with the earliest cycle it may appear at the output. That cycle is
// accept+2, or (previous word's transfer)+1 if that is later. From this the bench
// predicts out_valid, out_data and count, and the round-robin grant, every cycle.
//
// Directed sequences add hand-computed literal expectations. These are followed
// by a randomized run with flushes and resets.
// -----------------------------------------------------------------------------
module tb_queue_ctrl;

  localparam int NUM_REQ     = 4;
  localparam int WIDTH       = 32;
  localparam int DEPTH_INDEX = 2;
  localparam int DEPTH       = 4;

  logic                     clk = 1'b0;
  logic                     rst, flush;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     q_rst, q_enqueue, q_dequeue;
  logic [WIDTH-1:0]         q_din;
  logic [WIDTH-1:0]         q_dout  = '0;
  logic                     q_empty = 1'b1;
  logic                     q_full  = 1'b0;
  logic                     out_valid, out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [DEPTH_INDEX:0]     count;

  always #5 clk = ~clk;

  queue_ctrl #(
    .NUM_REQ     (NUM_REQ),
    .WIDTH       (WIDTH),
    .DEPTH_INDEX (DEPTH_INDEX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .q_rst     (q_rst),
    .q_din     (q_din),
    .q_enqueue (q_enqueue),
    .q_dequeue (q_dequeue),
    .q_dout    (q_dout),
    .q_empty   (q_empty),
    .q_full    (q_full),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  // ---------------------------------------------------------------------------
  // Attached queue model. dout is deliberately left untouched by reset, so a
  // stale value would show if the controller ever presented it.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] qmem[$];

  always @(posedge clk) begin
    if (q_rst) begin
      qmem.delete();
      q_empty <= 1'b1;
      q_full  <= 1'b0;
    end else begin
      if (q_dequeue && !q_empty) q_dout <= qmem.pop_front();
      if (q_enqueue && !q_full)  qmem.push_back(q_din);
      q_empty <= (qmem.size() == 0);
      q_full  <= (qmem.size() == DEPTH);
    end
  end

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and per-cycle compare
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [WIDTH-1:0] data;
    int unsigned      elig;
  } item_t;

  item_t sb[$];
  int    rr       = 0;
  bit    model_en = 1'b0;

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_ready;
    int                 g;
    int                 idx;
    bit                 clr;
    bit                 exp_ov;
    item_t              it;
    if (model_en) begin
      clr       = rst || flush;
      exp_ready = '0;
      g         = -1;
      if (!clr && !q_full) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (rr + k) % NUM_REQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_ov = !clr && sb.size() > 0 && sb[0].elig <= cyc;

      check("req_ready", req_ready, exp_ready);
      check("q_enqueue", q_enqueue, (g >= 0));
      if (g >= 0) check("q_din", q_din, req_data[g*WIDTH +: WIDTH]);
      check("out_valid", out_valid, exp_ov);
      if (exp_ov) check("out_data", out_data, sb[0].data);
      check("count", count, sb.size());
      check("q_rst", q_rst, clr);
      check("deq_while_empty", (q_dequeue && q_empty), 1'b0);
      check("enq_while_full", (q_enqueue && q_full), 1'b0);

      if (clr) begin
        sb.delete();
        rr = 0;
      end else begin
        if (exp_ov && out_ready) begin
          void'(sb.pop_front());
          if (sb.size() > 0 && sb[0].elig < cyc + 1) sb[0].elig = cyc + 1;
        end
        if (g >= 0) begin
          it.data = req_data[g*WIDTH +: WIDTH];
          it.elig = cyc + 2;
          sb.push_back(it);
          rr = (g + 1) % NUM_REQ;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (count == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1'b1);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int got;
    bit acc;

    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_en = 1'b1;

    // Reset values, taken while rst is still asserted.
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_q_enqueue", q_enqueue, 1'b0);
    check("rst_q_dequeue", q_dequeue, 1'b0);
    tick();
    rst = 1'b0;

    // Single word from req0.
    out_ready = 1'b1;
    req_valid = 4'b0001;
    req_data[0 +: WIDTH] = 32'hA5A5_0001;
    @(negedge clk);
    check("single_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("single_cnt_t1", count, 1);
    check("single_ov_t1", out_valid, 1'b0);
    check("single_deq_t1", q_dequeue, 1'b1);
    tick();
    @(negedge clk);
    check("single_ov_t2", out_valid, 1'b1);
    check("single_data_t2", out_data, 32'hA5A5_0001);
    tick();
    @(negedge clk);
    check("single_cnt_t3", count, 0);
    check("single_ov_t3", out_valid, 1'b0);
    tick();

    // All four requesters valid: strict rotation, bubble-free output.
    do_flush();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = 32'h100 + i;
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_order", q_din, 32'h100 + (k % 4));
      if (k >= 2) begin
        check("rr_stream_valid", out_valid, 1'b1);
        check("rr_stream_data", out_data, 32'h100 + ((k - 2) % 4));
      end
      tick();
    end
    req_valid = '0;
    wait_idle("rr_drain_idle");

    // Backpressure: 4 queued + 1 held, then requests blocked while full.
    do_flush();
    out_ready = 1'b0;
    req_valid = 4'b0001;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      req_data[0 +: WIDTH] = n;
      @(negedge clk);
      acc = req_ready[0];
      tick();
      if (acc) n++;
    end
    @(negedge clk);
    check("full_accepted", n, 5);
    check("full_count", count, 5);
    check("full_req_ready", req_ready, 4'b0000);
    tick();

    // Drain in order while req1 waits for a free slot.
    req_valid = 4'b0010;
    out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && got < 5; k++) begin
      req_data[WIDTH +: WIDTH] = 32'h200 + k;
      @(negedge clk);
      if (k == 0) check("full_blocks_req1", req_ready, 4'b0000);
      if (out_valid) begin
        check("drain_order", out_data, got);
        got++;
      end
      tick();
    end
    check("drain_count", got, 5);
    req_valid = '0;
    wait_idle("full_drain_idle");

    // Flush with three words outstanding and one presented.
    out_ready = 1'b0;
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      req_data[0 +: WIDTH] = 32'h300 + k;
      tick();
    end
    req_valid = '0;
    tick();
    tick();
    @(negedge clk);
    check("pre_flush_count", count, 3);
    check("pre_flush_ov", out_valid, 1'b1);
    check("pre_flush_data", out_data, 32'h300);
    tick();
    out_ready = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    check("flush_ov_forced", out_valid, 1'b0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("post_flush_count", count, 0);
    check("post_flush_ov", out_valid, 1'b0);
    tick();
    req_valid = 4'b0001;
    req_data[0 +: WIDTH] = 32'hBEEF_0000;
    @(negedge clk);
    check("post_flush_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    check("post_flush_ov_t2", out_valid, 1'b1);
    check("post_flush_data_t2", out_data, 32'hBEEF_0000);
    tick();

    // Reset in the middle of a stream.
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = $urandom;
      tick();
    end
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_count", count, 0);
    check("mid_rst_ov", out_valid, 1'b0);
    check("mid_rst_ready", req_ready, 4'b0000);
    check("mid_rst_enq", q_enqueue, 1'b0);
    check("mid_rst_deq", q_dequeue, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mid_rst_no_stale", out_valid, 1'b0);
      tick();
    end

    // Randomized traffic, with consumer pressure varied per block.
    for (int blk = 0; blk < 6; blk++) begin
      int ready_pct;
      ready_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 60 : 95);
      for (int k = 0; k < 500; k++) begin
        req_valid = NUM_REQ'($urandom);
        for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = $urandom;
        out_ready = ($urandom_range(0, 99) < ready_pct);
        flush     = ($urandom_range(0, 79) == 0);
        rst       = ($urandom_range(0, 299) == 0);
        tick();
      end
    end
    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got %0d errors so far, expected completion", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/queue_ctrl.md
Name: queue_ctrl

Overview:
- Controller that shares one `queue` instance between NUM_REQ producers and drains it to a single consumer.
- Producer side: round-robin arbitration over valid/ready requesters; drives the queue's enqueue/din.
- Consumer side: turns the queue's registered-dout dequeue protocol into a full-throughput valid/ready stream.
- Also keeps an occupancy count and provides a synchronous flush. Sits between fetch/issue producers and the downstream stage in mp_ooo.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 32, entry width in bits
DEPTH_INDEX, 4, log2 of queue depth; must match the attached queue

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous discard of all queued/held data
req_valid  in  NUM_REQ  per-requester valid
req_data  in  NUM_REQ x WIDTH  per-requester payload
req_ready  out  NUM_REQ  one-hot (or zero) accept
q_rst  out  1  rst | flush, wired to queue rst
q_din  out  WIDTH  payload to queue
q_enqueue  out  1  queue enqueue
q_dequeue  out  1  queue dequeue
q_dout  in  WIDTH  queue registered output
q_empty  in  1  queue empty flag (registered)
q_full  in  1  queue full flag (registered)
out_valid  out  1  consumer valid
out_data  out  WIDTH  consumer payload
out_ready  in  1  consumer ready
count  out  DEPTH_INDEX+1  entries in queue plus held output entry

Behaviour:
- Queue contract:
  - enqueue is ignored when full.
  - dequeue loads dout at the next edge; dout holds until the next dequeue.
  - Flags are registered.
  - Simultaneous enq+deq on a non-empty queue is legal and leaves the flags unchanged.
- Enqueue must never be asserted while q_full=1.
- Dequeue must never be asserted while q_empty=1. This makes the queue's empty-bypass path unreachable by construction.
- Arbitration (combinational grant, registered pointer rr_ptr):
  - grant = first i with req_valid[i], searching from rr_ptr upward with wrap.
  - req_ready = grant & ~q_full & ~flush.
  - On accept (req_valid[g] & req_ready[g]): q_enqueue=1, q_din=req_data[g], rr_ptr <= (g+1) mod NUM_REQ.
  - With no accept, rr_ptr holds. req_ready never depends on out_ready.
- Output FSM, 2 states:
  - EMPTY: out_valid=0. If ~q_empty: q_dequeue=1, next VALID.
  - VALID: out_valid=1, out_data=q_dout.
    - out_ready & ~q_empty: q_dequeue=1, stay VALID; a new word appears next cycle with no bubble.
    - out_ready & q_empty: next EMPTY.
    - ~out_ready: hold, no dequeue.
- Latency: accept at cycle t, then q_empty falls at t+1, q_dequeue at t+1, out_valid at t+2.
- Throughput: 1 word/cycle sustained when the queue is non-empty and out_ready=1.
- count:
  - +1 on accept, -1 on out_valid&out_ready, unchanged when both occur.
  - Range 0..2^DEPTH_INDEX+1 (queue capacity 2^DEPTH_INDEX plus the held word).
  - Width DEPTH_INDEX+1 saturates at 2^(DEPTH_INDEX+1)-1, which is never exceeded for DEPTH_INDEX>=1.
- Reset/flush, same cycle:
  - rr_ptr<=0, FSM<=EMPTY, count<=0, q_rst=1.
  - req_ready=0, q_enqueue=0, q_dequeue=0.
  - out_valid is 0 from the next cycle.
  - Flush mid-handshake drops the held word; the consumer must not count a transfer in the flush cycle. out_valid is forced 0 combinationally during flush.
- Reset values: out_valid=0, req_ready=0, q_enqueue=0, q_dequeue=0, count=0.

Decomposition:
- Shared package: no new typedefs. Use localparam DEPTH = 2**DEPTH_INDEX and the FSM state enum (EMPTY, VALID) in a queue_ctrl_pkg if other controllers reuse it; otherwise local.
- Sub-module rr_arbiter (NUM_REQ; req, accept -> grant, rr_ptr register) is natural and reusable.
- The queue itself is instantiated by the parent, not inside this block.

Test Plan:
- Single req0 write 0xA5A5_0001 at cycle t, out_ready=1 -> out_valid at t+2 with 0xA5A5_0001; count 1 at t+1, 0 after the transfer at t+2.
- All 4 reqs valid continuously with payload = 0x100+i, out_ready=1 -> accept order 0,1,2,3,0,... one per cycle; outputs in the same order with no bubbles after the first.
- out_ready=0, req0 streams 0..N with DEPTH_INDEX=2 -> 4 queued + 1 held, count=5, then req_ready=0 while q_full=1. Raise out_ready -> 0,1,2,3,4 in order, req_ready resumes the cycle after q_full drops.
- Full queue, out_ready=1, req1 valid -> q_full=1 blocks enqueue (req_ready=0). The dequeue frees a slot; the next cycle accepts, with no loss or duplication.
- Flush while out_valid=1 and count=3 -> next cycle out_valid=0, count=0, rr_ptr=0. A new write then appears 2 cycles after accept.
- rst asserted mid-stream for 1 cycle -> all outputs at reset values the following cycle; no stale q_dout is presented (out_valid stays 0 until a new accept).
